// File: rtl/rbe_conv_packer_pkg.sv
// Shared sizing and types for the RBE output packer that feeds the streamer conv sink.
package rbe_conv_packer_pkg;

  localparam int unsigned BITS_PER_TCDM_PORT = 32;
  localparam int unsigned NR_TCDM_PORTS      = 9;
  localparam int unsigned PACKER_LANES       = BITS_PER_TCDM_PORT * NR_TCDM_PORTS / 32;
  localparam int unsigned PACKER_CNT_W       = 16;

  typedef enum logic {
    PK_FILL = 1'b0,
    PK_HOLD = 1'b1
  } packer_state_t;

  // Packer status, aggregated into the accelerator's top-level flags.
  typedef struct packed {
    logic                    busy;
    logic [PACKER_CNT_W-1:0] beat_cnt;
  } flags_packer_t;

endpackage

// File: rtl/rbe_conv_packer.sv
// Packs IW-bit elements into BW-bit TCDM words with byte strobes; a last-marked
// element flushes a partial word so tiles need not fill every lane.
module rbe_conv_packer
  import rbe_conv_packer_pkg::*;
#(
  parameter int unsigned IW    = 32,
  parameter int unsigned BW    = 288,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              enable_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [IW-1:0]     in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [BW-1:0]     out_data_o,
  output logic [BW/8-1:0]   out_strb_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  beat_cnt_o
);

  localparam int unsigned LANES = BW / IW;
  localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned LB    = IW / 8;

  if (BW % IW != 0) begin : g_bw_check
    $error("rbe_conv_packer: BW must be a multiple of IW");
  end
  if (IW % 8 != 0) begin : g_iw_check
    $error("rbe_conv_packer: IW must be a multiple of 8");
  end

  packer_state_t     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [BW-1:0]     data_q, data_d;
  logic [BW/8-1:0]   strb_q, strb_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept;

  assign accept = in_valid_i && in_ready_o;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q <= PK_FILL;
      idx_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
      cnt_q   <= cnt_d;
    end
  end

  // A HOLD word leaving downstream may coincide with the first element of the next word.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    strb_d  = strb_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      PK_FILL: begin
        if (accept) begin
          data_d[idx_q*IW +: IW] = in_data_i;
          strb_d[idx_q*LB +: LB] = '1;
          if ((idx_q == IDX_W'(LANES - 1)) || in_last_i) begin
            state_d = PK_HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      PK_HOLD: begin
        if (out_ready_i) begin
          cnt_d   = cnt_q + 1'b1;
          data_d  = '0;
          strb_d  = '0;
          idx_d   = '0;
          state_d = PK_FILL;
          if (accept) begin
            data_d[IW-1:0] = in_data_i;
            strb_d[LB-1:0] = '1;
            if ((LANES == 1) || in_last_i) begin
              state_d = PK_HOLD;
            end else begin
              idx_d = IDX_W'(1);
            end
          end
        end
      end
      default: state_d = PK_FILL;
    endcase
  end

  always_comb begin
    out_valid_o = (state_q == PK_HOLD);
    in_ready_o  = enable_i && ((state_q == PK_FILL) || out_ready_i);
    out_data_o  = data_q;
    out_strb_o  = strb_q;
    busy_o      = (state_q == PK_HOLD) || (idx_q != '0);
    beat_cnt_o  = cnt_q;
  end

endmodule

// File: tb/tb_rbe_conv_packer.sv
// Scoreboard bench for rbe_conv_packer: a queue-based element model predicts words,
// handshakes and counters; a separate monitor checks every presented word.
module tb_rbe_conv_packer;

  localparam int IW    = 32;
  localparam int BW    = 288;
  localparam int LANES = BW / IW;
  localparam int CNT_W = 4;

  typedef struct {
    logic [BW-1:0]   d;
    logic [BW/8-1:0] s;
  } word_t;

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              clear_i = 1'b0;
  logic              enable_i = 1'b1;
  logic              in_valid_i = 1'b0;
  logic              in_ready_o;
  logic [IW-1:0]     in_data_i = '0;
  logic              in_last_i = 1'b0;
  logic              out_valid_o;
  logic              out_ready_i = 1'b0;
  logic [BW-1:0]     out_data_o;
  logic [BW/8-1:0]   out_strb_o;
  logic              busy_o;
  logic [CNT_W-1:0]  beat_cnt_o;

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  // Reference model state: elements of the word being gathered, pending-word flag, beats.
  logic [IW-1:0] cur[$];
  word_t         expQ[$];
  bit            mHold = 0;
  int            mBeat = 0;

  rbe_conv_packer #(.IW(IW), .BW(BW), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .enable_i    (enable_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_strb_o  (out_strb_o),
    .busy_o      (busy_o),
    .beat_cnt_o  (beat_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: checks handshake/status signals, then advances by the coming clock edge.
  always @(negedge clk) begin
    logic    expReady;
    word_t   w;
    expReady = enable_i && (!mHold || out_ready_i);
    if (armed) begin
      checkOutput("out_valid", BW'(out_valid_o), BW'(mHold));
      checkOutput("in_ready", BW'(in_ready_o), BW'(expReady));
      checkOutput("busy", BW'(busy_o), BW'(mHold || (cur.size() != 0)));
      checkOutput("beat_cnt", BW'(beat_cnt_o), BW'(mBeat));
    end
    if (rst_i || clear_i) begin
      cur.delete();
      expQ.delete();
      mHold = 0;
      mBeat = 0;
    end else if (armed) begin
      if (mHold && out_ready_i) begin
        mBeat = (mBeat + 1) % (1 << CNT_W);
        mHold = 0;
      end
      if (in_valid_i && expReady) begin
        cur.push_back(in_data_i);
        if (cur.size() == LANES || in_last_i) begin
          w.d = '0;
          w.s = '0;
          for (int i = 0; i < cur.size(); i++) begin
            w.d[i*IW +: IW]       = cur[i];
            w.s[i*(IW/8) +: IW/8] = '1;
          end
          expQ.push_back(w);
          cur.delete();
          mHold = 1;
        end
      end
    end
  end

  // Monitor: compares each presented word with the scoreboard head, pops on acceptance.
  always @(negedge clk) begin
    if (armed && !rst_i && !clear_i && out_valid_o === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_word: got data %h with no word expected", out_data_o);
      end else begin
        checkOutput("word_data", out_data_o, expQ[0].d);
        checkOutput("word_strb", BW'(out_strb_o), BW'(expQ[0].s));
        if (out_ready_i) void'(expQ.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [IW-1:0] d, input logic last);
    bit done;
    done       = 0;
    in_valid_i = 1'b1;
    in_data_i  = d;
    in_last_i  = last;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = (in_ready_o === 1'b1);
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no handshake expected one within 100 cycles");
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic summary();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
    summary();
    $finish;
  end

  initial begin
    idle(3);
    rst_i = 1'b0;
    armed = 1;
    checkOutput("reset_data", out_data_o, '0);
    checkOutput("reset_strb", BW'(out_strb_o), '0);
    checkOutput("reset_valid", BW'(out_valid_o), '0);
    checkOutput("reset_cnt", BW'(beat_cnt_o), '0);

    $display("[TB] full word 1..9");
    out_ready_i = 1'b1;
    for (int k = 0; k < LANES; k++) applyStimulus(IW'(k + 1), 1'b0);
    idle(2);
    checkOutput("cnt_after_first", BW'(beat_cnt_o), BW'(1));

    $display("[TB] partial word with last on 4th");
    for (int k = 0; k < 4; k++) applyStimulus($urandom, k == 3);
    idle(2);

    $display("[TB] streaming 27 elements");
    for (int k = 0; k < 3 * LANES; k++) applyStimulus($urandom, 1'b0);
    idle(2);

    $display("[TB] backpressure");
    out_ready_i = 1'b0;
    for (int k = 0; k < LANES; k++) applyStimulus($urandom, 1'b0);
    in_valid_i = 1'b1;
    in_data_i  = $urandom;
    idle(5);
    out_ready_i = 1'b1;
    applyStimulus($urandom, 1'b0);
    for (int k = 1; k < LANES; k++) applyStimulus($urandom, 1'b0);
    idle(2);

    $display("[TB] clear mid-word");
    for (int k = 0; k < 5; k++) applyStimulus($urandom, 1'b0);
    clear_i = 1'b1;
    idle(1);
    clear_i = 1'b0;
    idle(1);
    for (int k = 0; k < LANES; k++) applyStimulus($urandom, 1'b0);
    idle(2);

    $display("[TB] enable low during hold");
    out_ready_i = 1'b0;
    for (int k = 0; k < LANES; k++) applyStimulus($urandom, 1'b0);
    enable_i   = 1'b0;
    in_valid_i = 1'b1;
    in_data_i  = $urandom;
    idle(2);
    out_ready_i = 1'b1;
    idle(2);
    enable_i = 1'b1;
    applyStimulus($urandom, 1'b1);
    idle(2);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      in_valid_i  = ($urandom_range(0, 99) < 70);
      in_data_i   = $urandom;
      in_last_i   = ($urandom_range(0, 99) < 12);
      out_ready_i = ($urandom_range(0, 99) < 70);
      enable_i    = ($urandom_range(0, 99) < 90);
      clear_i     = ($urandom_range(0, 99) < 2);
      idle(1);
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    clear_i    = 1'b0;
    enable_i   = 1'b1;
    out_ready_i = 1'b1;
    idle(3);

    $display("[TB] beat counter wrap");
    rst_i = 1'b1;
    idle(1);
    rst_i = 1'b0;
    for (int k = 0; k < 16 * LANES; k++) applyStimulus($urandom, 1'b0);
    idle(2);
    checkOutput("wrap_cnt", BW'(beat_cnt_o), '0);

    for (int n = 0; n < 50 && expQ.size() != 0; n++) idle(1);
    checkOutput("drain", BW'(expQ.size()), '0);
    summary();
    $finish;
  end

endmodule

// File: doc/rbe_conv_packer.md
Name: rbe_conv_packer

Overview:
- Sits directly upstream of the streamer's conv_i sink.
- Gathers narrow output elements from the RBE normalization/quantization stage, one IW-bit element per handshake, into BW-bit words with byte strobes.
- Each full word becomes one TCDM store beat.
- A last-marked element flushes a partial word early, so output tiles need not be a multiple of LANES elements.

Parameters:
- IW, 32, width of one input element in bits; must be a multiple of 8.
- BW, 288, output word width (BITS_PER_TCDM_PORT * NR_TCDM_PORTS); must be a multiple of IW.
- CNT_W, 16, width of the emitted-beat counter.
- LANES, BW/IW (localparam, default 9), elements per output word.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- clear_i  in  1  synchronous local clear; same effect as rst_i.
- enable_i  in  1  gates input acceptance only.
- in_valid_i  in  1  input element valid.
- in_ready_o  out  1  input element ready.
- in_data_i  in  IW  input element.
- in_last_i  in  1  last element of tile; forces flush.
- out_valid_o  out  1  packed word valid (drives conv_i valid).
- out_ready_i  in  1  packed word ready (from conv_i).
- out_data_o  out  BW  packed word; lane k occupies bits [k*IW +: IW].
- out_strb_o  out  BW/8  byte strobe; high for bytes of filled lanes.
- busy_o  out  1  high when any lane is filled or a word is pending.
- beat_cnt_o  out  CNT_W  number of words accepted downstream since reset/clear; wraps modulo 2^CNT_W.

Behaviour:
- Reset and clear values:
  - rst_i or clear_i at a clock edge sets state=FILL, lane index=0, data buffer=0, strobe=0, beat_cnt=0.
  - Outputs after reset: out_valid_o=0, in_ready_o=enable_i, out_data_o=0, out_strb_o=0, busy_o=0, beat_cnt_o=0.
  - rst_i has priority over clear_i.
  - Reset or clear mid-word discards the partial word silently; no flush is emitted.
- States:
  - FILL: accumulating elements; out_valid_o=0.
  - HOLD: word complete; out_valid_o=1.
- Input handshake: an element is accepted when in_valid_i && in_ready_o.
  - in_ready_o = enable_i && (state==FILL || out_ready_i).
- FILL, element accepted:
  - Write in_data_i into lane idx and set the strobe bytes for that lane.
  - If idx==LANES-1 or in_last_i: go to HOLD, idx<=0.
  - Otherwise idx<=idx+1.
- HOLD, out_ready_i=1 (word accepted):
  - beat_cnt<=beat_cnt+1.
  - If an element is also accepted in the same cycle, it starts a fresh word: lane 0 <= in_data_i and strobe <= lane-0 bytes only.
  - The new word goes straight back to HOLD if LANES==1 or in_last_i; otherwise go to FILL with idx=1.
  - If no element is accepted, go to FILL with strobe=0 and data=0.
- HOLD, out_ready_i=0:
  - out_data_o and out_strb_o stay stable and out_valid_o stays high (stream protocol: valid never drops before ready).
- enable_i=0:
  - Blocks input acceptance only.
  - A pending HOLD word is still presented and can be accepted.
- Latency and throughput:
  - out_valid_o rises 1 cycle after the handshake of the word's final element.
  - Sustained throughput is 1 element/cycle with back-to-back words; there are no bubble cycles when out_ready_i is held high.
- in_last_i handling:
  - in_last_i on an element landing in lane LANES-1 produces a single full word, never an extra empty word.
  - in_last_i arriving when idx==0 in FILL produces a word with a single-lane strobe.
- busy_o = (state==HOLD) || (idx!=0).
- Unfilled lanes of a partial word read as 0.
- Arithmetic:
  - idx is clog2(LANES) bits wide and never exceeds LANES-1.
  - beat_cnt wraps silently from all-ones to 0.

Decomposition:
- rbe_package gains:
  - localparam PACKER_LANES = BITS_PER_TCDM_PORT*NR_TCDM_PORTS/32.
  - packer_state_t enum {PK_FILL, PK_HOLD}.
  - flags_packer_t struct {busy; beat_cnt}, for aggregation into the top-level flags.
- Single module with no sub-module; lane counter and strobe generation are inline.
- Elaboration-time asserts: BW%IW==0 and IW%8==0.

Test Plan:
- Reset then 9 elements 0x1..0x9 with out_ready_i=1 → one word, lane k = k+1, strobe all 36 ones, out_valid_o 1 cycle after the 9th handshake, beat_cnt_o=1.
- 4 elements with in_last_i on the 4th → word strobe 0x0000FFFF (bytes 0-15), lanes 4-8 = 0, then FILL with idx=0.
- Stream 27 elements at 1/cycle with out_ready_i=1 → 3 words, in_ready_o never low, beat_cnt_o=3.
- Hold out_ready_i=0 for 5 cycles while a word is pending:
  - out_data_o and out_strb_o stable, in_ready_o=0.
  - Then raise ready with in_valid_i=1 → word accepted and the new element lands in lane 0 in the same cycle.
- Push 5 elements, pulse clear_i → busy_o=0, no word emitted, next 9 elements form a clean word.
- enable_i=0 while HOLD → word still accepted on out_ready_i, in_ready_o=0 until enable_i=1.
- beat_cnt wrap → force 65536 words (or use CNT_W=4 build: 16 words) → beat_cnt_o returns to 0.
